// File: rtl/dvr_rr_arbiter_if.sv
// dvr_rr_arbiter_if: valid/ready bundle between N requesters and one shared output channel.
interface dvr_rr_arbiter_if #(
    parameter int DATA_TYPE  = 32,
    parameter int NUM_INPUTS = 4,
    parameter int INDEX_TYPE = 2
);
    logic [NUM_INPUTS*DATA_TYPE-1:0] ins;
    logic [NUM_INPUTS-1:0]           ins_valid;
    logic [NUM_INPUTS-1:0]           ins_ready;
    logic [DATA_TYPE-1:0]            outs;
    logic [INDEX_TYPE-1:0]           index;
    logic                            outs_valid;
    logic                            outs_ready;
    modport master (output ins, ins_valid, outs_ready, input ins_ready, outs, index, outs_valid);
    modport slave  (input ins, ins_valid, outs_ready, output ins_ready, outs, index, outs_valid);
endinterface

// File: rtl/dvr_rr_arbiter.sv
// dvr_rr_arbiter: round-robin arbiter with bounded bursts feeding one registered output slot.
module dvr_rr_arbiter #(
    parameter int DATA_TYPE  = 32,
    parameter int NUM_INPUTS = 4,
    parameter int INDEX_TYPE = 2,
    parameter int MAX_BURST  = 1
) (
    input logic               clk,
    input logic               rst,
    dvr_rr_arbiter_if.slave   bus
);
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [DATA_TYPE-1:0]  outs_q, outs_d;
    logic [INDEX_TYPE-1:0] index_q, index_d, last_q, last_d, win;
    logic [BW-1:0]         cnt_q, cnt_d;
    logic                  vld_q, vld_d, en, keep, xfer;
    logic [NUM_INPUTS-1:0] grant;
    assign en             = !vld_q || bus.outs_ready;
    assign xfer           = en && |grant;
    assign bus.ins_ready  = (en && rst) ? grant : '0;
    assign bus.outs       = outs_q;
    assign bus.index      = index_q;
    assign bus.outs_valid = vld_q;
    always_comb begin
        // cnt_q==0 means no burst in progress, so input 0 leads after reset
        keep = bus.ins_valid[last_q] && cnt_q != '0 && cnt_q < BW'(MAX_BURST);
        win  = last_q;
        // descending scan: the nearest valid successor is written last and wins
        if (!keep)
            for (int k = NUM_INPUTS; k >= 1; k--)
                if (bus.ins_valid[(int'(last_q) + k) % NUM_INPUTS])
                    win = INDEX_TYPE'((int'(last_q) + k) % NUM_INPUTS);
        grant      = '0;
        grant[win] = |bus.ins_valid;
        outs_d     = outs_q;
        index_d    = index_q;
        vld_d      = vld_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        if (xfer) begin
            outs_d  = bus.ins[int'(win)*DATA_TYPE +: DATA_TYPE];
            index_d = win;
            vld_d   = 1'b1;
            last_d  = win;
            cnt_d   = keep ? cnt_q + 1'b1 : BW'(1);
        end else if (en) begin
            vld_d = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outs_q  <= '0;
            index_q <= '0;
            vld_q   <= 1'b0;
            last_q  <= INDEX_TYPE'(NUM_INPUTS - 1);
            cnt_q   <= '0;
        end else begin
            outs_q  <= outs_d;
            index_q <= index_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_dvr_rr_arbiter.sv
// tb_dvr_rr_arbiter: directed checks of round-robin, bursts, backpressure, idle and reset.
module tb_dvr_rr_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    dvr_rr_arbiter_if #(.DATA_TYPE(32), .NUM_INPUTS(4), .INDEX_TYPE(2)) a ();
    dvr_rr_arbiter_if #(.DATA_TYPE(32), .NUM_INPUTS(4), .INDEX_TYPE(2)) b ();
    dvr_rr_arbiter #(.DATA_TYPE(32), .NUM_INPUTS(4), .INDEX_TYPE(2), .MAX_BURST(1)) dut_a (
        .clk(clk), .rst(rst), .bus(a.slave));
    dvr_rr_arbiter #(.DATA_TYPE(32), .NUM_INPUTS(4), .INDEX_TYPE(2), .MAX_BURST(2)) dut_b (
        .clk(clk), .rst(rst), .bus(b.slave));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    int burst_seq[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int drop_seq[4]   = '{2, 2, 3, 3};
    initial begin
        rst = 1'b0;
        a.ins = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        b.ins = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        a.ins_valid = 4'b0000; a.outs_ready = 1'b1;
        b.ins_valid = 4'b0000; b.outs_ready = 1'b1;
        #2;
        check("rst_valid", {31'b0, a.outs_valid}, 0);
        check("rst_index", {30'b0, a.index}, 0);
        check("rst_outs", a.outs, 0);
        a.ins_valid = 4'b1111;
        #1;
        check("rst_ready_low", {28'b0, a.ins_ready}, 0);
        tick(); tick();
        rst = 1'b1;
        #1;
        check("rr_first_ready", {28'b0, a.ins_ready}, 32'h1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_valid", {31'b0, a.outs_valid}, 1);
            check("rr_index", {30'b0, a.index}, k % 4);
            check("rr_outs", a.outs, 32'hA0 + (k % 4));
        end
        a.outs_ready = 1'b0;
        #1;
        check("bp_ready", {28'b0, a.ins_ready}, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_valid", {31'b0, a.outs_valid}, 1);
            check("bp_index", {30'b0, a.index}, 1);
            check("bp_outs", a.outs, 32'hA1);
            check("bp_ready_hold", {28'b0, a.ins_ready}, 0);
        end
        a.outs_ready = 1'b1;
        #1;
        check("bp_resume_ready", {28'b0, a.ins_ready}, 32'h4);
        for (int k = 2; k < 5; k++) begin
            tick();
            check("bp_resume_index", {30'b0, a.index}, k % 4);
            check("bp_resume_outs", a.outs, 32'hA0 + (k % 4));
        end
        a.ins_valid = 4'b0000;
        tick();
        check("idle_valid", {31'b0, a.outs_valid}, 0);
        check("idle_index_hold", {30'b0, a.index}, 0);
        tick();
        check("idle_valid2", {31'b0, a.outs_valid}, 0);
        check("idle_ready", {28'b0, a.ins_ready}, 0);
        a.ins_valid = 4'b1000;
        #1;
        check("late_ready", {28'b0, a.ins_ready}, 32'h8);
        tick();
        check("late_valid", {31'b0, a.outs_valid}, 1);
        check("late_index", {30'b0, a.index}, 3);
        check("late_outs", a.outs, 32'hA3);
        #1 rst = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, a.outs_valid}, 0);
        check("async_rst_outs", a.outs, 0);
        check("async_rst_ready", {28'b0, a.ins_ready}, 0);
        a.ins_valid = 4'b0000;
        tick();
        rst = 1'b1;
        b.ins_valid = 4'b1111;
        #1;
        check("burst_first_ready", {28'b0, b.ins_ready}, 32'h1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("burst_valid", {31'b0, b.outs_valid}, 1);
            check("burst_index", {30'b0, b.index}, burst_seq[k]);
            check("burst_outs", b.outs, 32'hB0 + burst_seq[k]);
        end
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("drop_head_index", {30'b0, b.index}, (k == 2) ? 1 : 0);
        end
        b.ins_valid = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("drop_index", {30'b0, b.index}, drop_seq[k]);
        end
        b.ins_valid = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("single_valid", {31'b0, b.outs_valid}, 1);
            check("single_index", {30'b0, b.index}, 2);
            check("single_outs", b.outs, 32'hB2);
        end
        b.ins_valid = 4'b0000;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dvr_rr_arbiter.md
Name: dvr_rr_arbiter

Overview:
- Shares one downstream elastic channel (typically a buffered dvr slot chain) among NUM_INPUTS requesting valid/ready channels.
- Round-robin arbitration with a bounded burst allowance; the winner's data is captured in a single full-throughput output register, tagged with the winner's index.
- Sits in front of shared buffering or shared functional units in handshake circuits.

Parameters:
- DATA_TYPE, 32, data width of every channel.
- NUM_INPUTS, 4, number of requesters (≥2).
- INDEX_TYPE, 2, width of the index output; must be ≥ clog2(NUM_INPUTS).
- MAX_BURST, 1, maximum consecutive grants to one input while others wait (≥1); 1 is pure round-robin.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- ins  input  NUM_INPUTS*DATA_TYPE  flattened input data; slice i is bits [i*DATA_TYPE +: DATA_TYPE].
- ins_valid  input  NUM_INPUTS  per-input valid.
- ins_ready  output  NUM_INPUTS  per-input ready, at most one bit high.
- outs  output  DATA_TYPE  registered winner data.
- index  output  INDEX_TYPE  registered winner input number, qualified by outs_valid.
- outs_valid  output  1  output valid.
- outs_ready  input  1  downstream ready.

Behaviour:
- Reset (rst=0, asynchronous): outs=0, index=0, outs_valid=0, burst_cnt=0, last_winner=NUM_INPUTS-1. ins_ready is forced to all-zero while rst=0. After release, input 0 has top priority.
- Load enable: en = !outs_valid || outs_ready.
- ins_ready[i] = en && grant[i].
- grant is combinational from ins_valid and state; it is one-hot or zero. ins_ready depends combinationally on ins_valid and outs_ready. There is no path from any input to outs/outs_valid.
- Transfer on input i: ins_valid[i] && ins_ready[i].
  - At the next edge: outs<=ins slice i, index<=i, outs_valid<=1.
  - Latency is 1 cycle; throughput is 1 transfer per cycle.
- If en=1 and no input is valid: outs_valid<=0 at the edge. outs/index hold. State does not change.
- If en=0 (outs_valid=1, outs_ready=0): outs, index and outs_valid are held stable. All ins_ready=0. last_winner and burst_cnt are frozen.
- Arbitration, evaluated every cycle; state updates only on a transfer:
  - Keep: if ins_valid[last_winner] && burst_cnt<MAX_BURST, last_winner wins and burst_cnt increments.
  - Rotate: otherwise, search inputs starting at (last_winner+1) mod NUM_INPUTS, wrapping. The first valid input wins. last_winner<=winner and burst_cnt<=1.
  - Work-conserving: if the rotate search finds only last_winner valid (its burst is exhausted), it still wins and burst_cnt<=1.
  - The wrap from NUM_INPUTS-1 to 0 is seamless.
  - burst_cnt saturates at MAX_BURST. Its width is clog2(MAX_BURST+1).
- A grant raised in a cycle with no transfer (en=0) is not committed. The winner is recomputed next cycle; no request is lost and no input gets a spurious handshake.
- Reset asserted mid-transfer discards the buffered output word. Upstream producers retain their own data because ins_ready is low during reset.
- index values ≥ NUM_INPUTS never occur.

Test Plan:
- Reset: NUM_INPUTS=4. Drive rst=0 asynchronously while outs_valid=1 → outs_valid=0 and ins_ready=4'b0000 before the next edge. After release with all inputs valid, the first index is 0.
- Pure round-robin: MAX_BURST=1, all four valid continuously with data 0xA0+i, outs_ready=1 → index sequence 0,1,2,3,0,1… with one word per cycle and outs=0xA0+index.
- Burst: MAX_BURST=2, all valid → index sequence 0,0,1,1,2,2,3,3,0,0. Drop input 1 after its first grant → sequence 0,0,1,2,2,3,3.
- Single requester: MAX_BURST=2, only ins_valid[2]=1 for 6 cycles → 6 consecutive transfers with index=2 and no bubble (work-conserving).
- Backpressure: all valid, outs_ready=0 for 3 cycles while outs_valid=1 with index=1 → outs/index stable, ins_ready=0000, no transfers. After outs_ready=1, the sequence resumes exactly where it stopped (next index per policy).
- Idle/late arrival: no inputs valid for 2 cycles → outs_valid falls to 0 after the pending word drains. Then input 3 is raised alone → its word appears with outs_valid=1 one cycle after its handshake, index=3.
